// File: rtl/sdp_ram_be.sv
// Single-clock simple dual-port RAM with per-byte write enables, 1/2-cycle read pipeline,
// selectable same-address read-during-write result and a built-in clear sequencer.
module sdp_ram_be #(
    parameter int unsigned     DW       = 32,
    parameter int unsigned     WORDS    = 256,
    parameter int unsigned     RD_LAT   = 1,
    parameter int unsigned     RDW_MODE = 0,
    parameter logic [DW-1:0]   CLR_VAL  = '0,
    localparam int unsigned    AW       = $clog2(WORDS),
    localparam int unsigned    BW       = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          init_busy,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [BW-1:0] wr_be,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    localparam logic [AW:0]   WORDS_C = (AW + 1)'(WORDS);
    localparam logic [AW-1:0] LAST_C  = AW'(WORDS - 1);

    typedef enum logic [1:0] {RESET, CLEAR, IDLE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_cnt;
    logic            clr_last;
    logic            wr_in, rd_in, rd_go;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [BW-1:0]   mem_be;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   rd_word;
    logic            v1;
    logic [DW-1:0]   d1;
    logic [DW-1:0]   mem [WORDS];

    assign clr_last = (clr_cnt == LAST_C);
    assign wr_in    = ({1'b0, wr_addr} < WORDS_C);
    assign rd_in    = ({1'b0, rd_addr} < WORDS_C);
    assign rd_go    = rst_n && (state == IDLE) && rd_en;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RESET;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RESET:   state_nxt = CLEAR;
            CLEAR:   if (clr_last) state_nxt = IDLE;
            IDLE:    if (clr_req)  state_nxt = CLEAR;
            default: state_nxt = RESET;
        endcase
    end

    always_comb begin
        init_busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                          clr_cnt <= '0;
        else if (state == CLEAR)             clr_cnt <= clr_cnt + AW'(1);
        else if (state == IDLE && clr_req)   clr_cnt <= '0;
    end

    // Clear sequencer and user writes share the single write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_be    = wr_be;
        mem_wdata = wr_data;
        if (state == CLEAR) begin
            mem_we    = rst_n;
            mem_addr  = clr_cnt;
            mem_be    = '1;
            mem_wdata = CLR_VAL;
        end else if (state == IDLE) begin
            mem_we    = rst_n && wr_en && wr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < BW; i++) begin
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Array read sees pre-write contents; new-data mode patches enabled lanes in.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = mem[rd_addr];
            if (RDW_MODE == 1 && mem_we && state == IDLE && wr_addr == rd_addr) begin
                for (int unsigned i = 0; i < BW; i++) begin
                    if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_go;
            if (rd_go) d1 <= rd_word;
        end
    end

    if (DW % 8 != 0) begin : g_bad_dw
        $error("sdp_ram_be: DW must be a multiple of 8");
    end

    if (RD_LAT == 1) begin : g_lat1
        assign rd_data  = d1;
        assign rd_valid = v1;
    end else if (RD_LAT == 2) begin : g_lat2
        logic          v2;
        logic [DW-1:0] d2;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end
        assign rd_data  = d2;
        assign rd_valid = v2;
    end else begin : g_bad_lat
        $error("sdp_ram_be: RD_LAT must be 1 or 2");
    end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Bench for sdp_ram_be: instance a (256 words, latency 1, old-data RDW) and
// instance b (100 words, latency 2, new-data RDW), checked against a queue of expected reads.
module tb_sdp_ram_be;

    localparam int unsigned AWA = 8;
    localparam int unsigned AWB = 7;
    localparam logic [31:0] CLR_A = 32'hA5A5A5A5;
    localparam logic [31:0] CLR_B = 32'h0F0F0F0F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            a_rst_n, a_clr_req, a_busy, a_wr_en, a_rd_en, a_rd_valid;
    logic [AWA-1:0]  a_wr_addr, a_rd_addr;
    logic [3:0]      a_wr_be;
    logic [31:0]     a_wr_data, a_rd_data;
    logic            b_rst_n, b_clr_req, b_busy, b_wr_en, b_rd_en, b_rd_valid;
    logic [AWB-1:0]  b_wr_addr, b_rd_addr;
    logic [3:0]      b_wr_be;
    logic [31:0]     b_wr_data, b_rd_data;

    sdp_ram_be #(.DW(32), .WORDS(256), .RD_LAT(1), .RDW_MODE(0), .CLR_VAL(CLR_A)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .clr_req(a_clr_req), .init_busy(a_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_be(a_wr_be), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
    );

    sdp_ram_be #(.DW(32), .WORDS(100), .RD_LAT(2), .RDW_MODE(1), .CLR_VAL(CLR_B)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .clr_req(b_clr_req), .init_busy(b_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    task automatic drive_a(input logic we, input logic [AWA-1:0] wa, input logic [3:0] be,
                           input logic [31:0] wd, input logic re, input logic [AWA-1:0] ra);
        a_wr_en = we; a_wr_addr = wa; a_wr_be = be; a_wr_data = wd;
        a_rd_en = re; a_rd_addr = ra;
    endtask

    task automatic drive_b(input logic we, input logic [AWB-1:0] wa, input logic [3:0] be,
                           input logic [31:0] wd, input logic re, input logic [AWB-1:0] ra);
        b_wr_en = we; b_wr_addr = wa; b_wr_be = be; b_wr_data = wd;
        b_rd_en = re; b_rd_addr = ra;
    endtask

    task automatic test_reset();
        int na, nb;
        a_rst_n = 1'b0; b_rst_n = 1'b0; a_clr_req = 1'b0; b_clr_req = 1'b0;
        drive_a(1'b0, '0, '0, '0, 1'b0, '0);
        drive_b(1'b0, '0, '0, '0, 1'b0, '0);
        repeat (3) @(negedge clk);
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL reset_busy_a got=%b exp=1", a_busy); end
        checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_a got=%b exp=0", a_rd_valid); end
        checks++; if (a_rd_data !== 32'h0) begin failures++; $display("FAIL reset_data_a got=%h exp=0", a_rd_data); end
        checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL reset_busy_b got=%b exp=1", b_busy); end
        checks++; if (b_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_b got=%b exp=0", b_rd_valid); end
        checks++; if (b_rd_data !== 32'h0) begin failures++; $display("FAIL reset_data_b got=%h exp=0", b_rd_data); end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        na = 0; nb = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (a_busy === 1'b1) na++;
            if (b_busy === 1'b1) nb++;
            if (a_busy === 1'b0 && b_busy === 1'b0) break;
        end
        checks++; if (na != 256) begin failures++; $display("FAIL busy_len_a got=%0d exp=256", na); end
        checks++; if (nb != 100) begin failures++; $display("FAIL busy_len_b got=%0d exp=100", nb); end
    endtask

    task automatic test_clear_contents();
        logic [31:0] ed;
        logic ev;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ev = (c >= 1 && c <= 3);
            checks++; if (a_rd_valid !== ev) begin failures++; $display("FAIL clr_valid_a c=%0d got=%b exp=%b", c, a_rd_valid, ev); end
            if (a_rd_valid === 1'b1 && exp_a.size() > 0) begin
                ed = exp_a.pop_front();
                checks++; if (a_rd_data !== ed) begin failures++; $display("FAIL clr_data_a c=%0d got=%h exp=%h", c, a_rd_data, ed); end
            end
            case (c)
                0: begin drive_a(1'b0, '0, '0, '0, 1'b1, 8'd0);   exp_a.push_back(CLR_A); end
                1: begin drive_a(1'b0, '0, '0, '0, 1'b1, 8'd128); exp_a.push_back(CLR_A); end
                2: begin drive_a(1'b0, '0, '0, '0, 1'b1, 8'd255); exp_a.push_back(CLR_A); end
                default: drive_a(1'b0, '0, '0, '0, 1'b0, '0);
            endcase
        end
        checks++; if (exp_a.size() != 0) begin failures++; $display("FAIL clr_missing_a left=%0d exp=0", exp_a.size()); exp_a.delete(); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] ed;
        logic ev;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ev = (c == 3);
            checks++; if (a_rd_valid !== ev) begin failures++; $display("FAIL be_valid_a c=%0d got=%b exp=%b", c, a_rd_valid, ev); end
            if (a_rd_valid === 1'b1 && exp_a.size() > 0) begin
                ed = exp_a.pop_front();
                checks++; if (a_rd_data !== ed) begin failures++; $display("FAIL be_data_a got=%h exp=%h", a_rd_data, ed); end
            end
            case (c)
                0: drive_a(1'b1, 8'd5, 4'hF, 32'hDEADBEEF, 1'b0, '0);
                1: drive_a(1'b1, 8'd5, 4'b0101, 32'h11223344, 1'b0, '0);
                2: begin drive_a(1'b0, '0, '0, '0, 1'b1, 8'd5); exp_a.push_back(32'hDE22BE44); end
                default: drive_a(1'b0, '0, '0, '0, 1'b0, '0);
            endcase
        end
        checks++; if (exp_a.size() != 0) begin failures++; $display("FAIL be_missing_a left=%0d exp=0", exp_a.size()); exp_a.delete(); end
        checks++; if (a_rd_data !== 32'hDE22BE44) begin failures++; $display("FAIL hold_data_a got=%h exp=DE22BE44", a_rd_data); end
    endtask

    task automatic test_rdw();
        logic [31:0] ed;
        logic eva, evb;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            eva = (c == 2 || c == 3);
            evb = (c == 3 || c == 4);
            checks++; if (a_rd_valid !== eva) begin failures++; $display("FAIL rdw_valid_a c=%0d got=%b exp=%b", c, a_rd_valid, eva); end
            if (a_rd_valid === 1'b1 && exp_a.size() > 0) begin
                ed = exp_a.pop_front();
                checks++; if (a_rd_data !== ed) begin failures++; $display("FAIL rdw_data_a c=%0d got=%h exp=%h", c, a_rd_data, ed); end
            end
            checks++; if (b_rd_valid !== evb) begin failures++; $display("FAIL rdw_valid_b c=%0d got=%b exp=%b", c, b_rd_valid, evb); end
            if (b_rd_valid === 1'b1 && exp_b.size() > 0) begin
                ed = exp_b.pop_front();
                checks++; if (b_rd_data !== ed) begin failures++; $display("FAIL rdw_data_b c=%0d got=%h exp=%h", c, b_rd_data, ed); end
            end
            case (c)
                0: begin
                    drive_a(1'b1, 8'd7, 4'hF, 32'h0, 1'b0, '0);
                    drive_b(1'b1, 7'd7, 4'hF, 32'h0, 1'b0, '0);
                end
                1: begin
                    drive_a(1'b1, 8'd7, 4'b0011, 32'hFFFFFFFF, 1'b1, 8'd7);
                    drive_b(1'b1, 7'd7, 4'b0011, 32'hFFFFFFFF, 1'b1, 7'd7);
                    exp_a.push_back(32'h00000000);
                    exp_b.push_back(32'h0000FFFF);
                end
                2: begin
                    drive_a(1'b0, '0, '0, '0, 1'b1, 8'd7);
                    drive_b(1'b0, '0, '0, '0, 1'b1, 7'd7);
                    exp_a.push_back(32'h0000FFFF);
                    exp_b.push_back(32'h0000FFFF);
                end
                default: begin
                    drive_a(1'b0, '0, '0, '0, 1'b0, '0);
                    drive_b(1'b0, '0, '0, '0, 1'b0, '0);
                end
            endcase
        end
        checks++; if (exp_a.size() + exp_b.size() != 0) begin
            failures++; $display("FAIL rdw_missing left=%0d exp=0", exp_a.size() + exp_b.size());
            exp_a.delete(); exp_b.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ed;
        logic ev;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ev = (c >= 6 && c <= 9);
            checks++; if (b_rd_valid !== ev) begin failures++; $display("FAIL pipe_valid_b c=%0d got=%b exp=%b", c, b_rd_valid, ev); end
            if (b_rd_valid === 1'b1 && exp_b.size() > 0) begin
                ed = exp_b.pop_front();
                checks++; if (b_rd_data !== ed) begin failures++; $display("FAIL pipe_data_b c=%0d got=%h exp=%h", c, b_rd_data, ed); end
            end
            if (c < 4) begin
                drive_b(1'b1, 7'(c), 4'hF, 32'hB0000000 + 32'(c), 1'b0, '0);
            end else if (c < 8) begin
                drive_b(1'b0, '0, '0, '0, 1'b1, 7'(c - 4));
                exp_b.push_back(32'hB0000000 + 32'(c - 4));
            end else begin
                drive_b(1'b0, '0, '0, '0, 1'b0, '0);
            end
        end
        checks++; if (exp_b.size() != 0) begin failures++; $display("FAIL pipe_missing_b left=%0d exp=0", exp_b.size()); exp_b.delete(); end
    endtask

    task automatic test_mid_clear();
        logic [31:0] ed;
        logic ev;
        int nb;
        logic saw_valid;
        saw_valid = 1'b0;
        b_clr_req = 1'b1;
        @(negedge clk);
        b_clr_req = 1'b0;
        checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL clr_req_busy_b got=%b exp=1", b_busy); end
        // User traffic held on throughout the busy window; all of it must be ignored.
        drive_b(1'b1, 7'd3, 4'hF, 32'hBAD00003, 1'b1, 7'd3);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (b_rd_valid !== 1'b0) saw_valid = 1'b1;
        end
        b_rst_n = 1'b0;
        @(negedge clk);
        checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_b got=%b exp=1", b_busy); end
        checks++; if (b_rd_data !== 32'h0) begin failures++; $display("FAIL midrst_data_b got=%h exp=0", b_rd_data); end
        b_rst_n = 1'b1;
        nb = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (b_rd_valid !== 1'b0) saw_valid = 1'b1;
            if (b_busy === 1'b1) nb++;
            else break;
        end
        drive_b(1'b0, '0, '0, '0, 1'b0, '0);
        checks++; if (nb != 100) begin failures++; $display("FAIL midrst_busy_len_b got=%0d exp=100", nb); end
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL busy_read_b got=%b exp=0", saw_valid); end
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            ev = (c >= 3 && c <= 6);
            checks++; if (b_rd_valid !== ev) begin failures++; $display("FAIL post_valid_b c=%0d got=%b exp=%b", c, b_rd_valid, ev); end
            if (b_rd_valid === 1'b1 && exp_b.size() > 0) begin
                ed = exp_b.pop_front();
                checks++; if (b_rd_data !== ed) begin failures++; $display("FAIL post_data_b c=%0d got=%h exp=%h", c, b_rd_data, ed); end
            end
            case (c)
                0: drive_b(1'b1, 7'd120, 4'hF, 32'hDEADBEEF, 1'b0, '0);
                1: begin drive_b(1'b0, '0, '0, '0, 1'b1, 7'd3);   exp_b.push_back(CLR_B); end
                2: begin drive_b(1'b0, '0, '0, '0, 1'b1, 7'd120); exp_b.push_back(32'h0); end
                3: begin drive_b(1'b0, '0, '0, '0, 1'b1, 7'd99);  exp_b.push_back(CLR_B); end
                4: begin drive_b(1'b0, '0, '0, '0, 1'b1, 7'd0);   exp_b.push_back(CLR_B); end
                default: drive_b(1'b0, '0, '0, '0, 1'b0, '0);
            endcase
        end
        checks++; if (exp_b.size() != 0) begin failures++; $display("FAIL post_missing_b left=%0d exp=0", exp_b.size()); exp_b.delete(); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear_contents();
        test_byte_enables();
        test_rdw();
        test_back_to_back();
        test_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdp_ram_be.md
# sdp_ram_be

Single-clock simple dual-port RAM: one write port with per-byte enables, one read port with a configurable 1- or 2-cycle read pipeline, and a `rd_valid` strobe. Same-address read-during-write behaviour is selectable. A built-in clear sequencer fills every word with a constant after reset or on request. It replaces the plain double-clock RAM wherever both ports share one clock and buffers need deterministic contents: line buffers, descriptor tables, FIFO storage.

## Interface
- `DW`, 32: data width in bits; must be a multiple of 8.
- `WORDS`, 256: number of words, ≥ 2; need not be a power of two.
- `RD_LAT`, 1: read latency in cycles; legal values 1 or 2. Any other value is an elaboration error.
- `RDW_MODE`, 0: same-address read-during-write result. 0 = old data; 1 = new data, merged per byte.
- `CLR_VAL`, 0: `DW`-bit value written to every word by the clear sequencer.
- Derived: `AW = $clog2(WORDS)`, `BW = DW/8`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `clr_req`  in  1  one-cycle pulse that starts a full clear; honoured only when idle.
- `init_busy`  out  1  high while reset or a clear sequence is in progress.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  AW  write address.
- `wr_be`  in  BW  byte enables; bit i covers `wr_data[8i+7:8i]`.
- `wr_data`  in  DW  write data.
- `rd_en`  in  1  read strobe.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  DW  read data.
- `rd_valid`  out  1  one-cycle strobe marking new `rd_data`.

## Operation
- Storage is `WORDS` × `DW`. `RD_LAT=1` uses a single output register. `RD_LAT=2` adds a second register stage for both `rd_data` and the valid bit.

FSM states: RESET, CLEAR, IDLE.
- Any edge with `rst_n=0`:
  - State goes to RESET. The clear counter goes to 0.
  - `init_busy`, `rd_data` and every pipeline stage go to 1, 0 and 0 respectively.
  - `rd_valid` goes to 0.
  - This applies in every state, including partway through CLEAR; the sequence then restarts from word 0.
- RESET → CLEAR on the first edge with `rst_n=1`.
- CLEAR:
  - Each edge writes `CLR_VAL` to the word at the counter address, then increments the counter.
  - On the edge that writes word `WORDS-1`, the FSM goes to IDLE and `init_busy` goes to 0.
- IDLE:
  - `clr_req=1` → counter to 0, state to CLEAR, `init_busy` to 1.
  - `clr_req` is ignored while busy.
- While `init_busy=1`:
  - `wr_en` and `rd_en` are ignored. No user write occurs and no new read is issued.
  - Reads already in the `RD_LAT=2` pipeline still complete.
- Write, in IDLE:
  - `wr_en=1` and `wr_addr<WORDS` → each byte lane with `wr_be[i]=1` is updated; other lanes keep their value.
  - `wr_addr≥WORDS` → the write is dropped.
- Read, in IDLE:
  - `rd_en=1` issues a read. `rd_addr≥WORDS` returns all-zero data.
  - `rd_valid` pulses exactly once per issued read.
  - `rd_data` holds its last value when no read completes.
- Same edge with `wr_en=1`, `rd_en=1` and `wr_addr==rd_addr` (in range):
  - `RDW_MODE=0`: the read returns the pre-write word.
  - `RDW_MODE=1`: the read returns the pre-write word with enabled lanes replaced by `wr_data`.
- `clr_req` on the same edge as a user write or read: the write and read are still executed on that edge, and clearing starts on the next edge.

## Timing
- Write becomes visible to a read issued on the next edge, regardless of `RDW_MODE`.
- Read issued at edge N:
  - `RD_LAT=1`: `rd_data` and `rd_valid=1` appear after edge N.
  - `RD_LAT=2`: they appear after edge N+1.
- Full throughput: one read and one write per cycle, back-to-back, with no bubbles.
- Clear duration: `init_busy` stays high for exactly `WORDS` cycles after the first `rst_n=1` edge, or after the `clr_req` edge. The first user access is accepted on the edge after `init_busy` falls.
- Reset values: `init_busy=1`, `rd_data=0`, `rd_valid=0`.

## Test plan
- **Reset clear:** `WORDS=256`, `CLR_VAL=32'hA5A5A5A5`. Hold `rst_n` low 3 cycles, then release. Required: `init_busy` high exactly 256 cycles. Reads of addresses 0, 128 and 255 then return `A5A5A5A5`.
- **Byte enables:** write `DEADBEEF` with `be=4'hF` to address 5, then `11223344` with `be=4'b0101`. Required: a read of address 5 returns `DE22BE44`.
- **Read-during-write:** address 7 holds `0`; same-edge write `FFFFFFFF` with `be=4'b0011` and read of address 7. Required: `RDW_MODE=0` returns `00000000`; `RDW_MODE=1` returns `0000FFFF`.
- **Pipelined reads:** `RD_LAT=2`, reads of addresses 0–3 on 4 consecutive edges. Required: `rd_valid` high for 4 consecutive cycles starting 2 edges after the first read, with data in address order.
- **Mid-clear events:** `WORDS=100` (not a power of two). Assert `rst_n=0` at clear count 40, then release. Required: the clear restarts and `init_busy` lasts 100 more cycles. Writes issued during busy are lost. A write to address 120 is dropped, and a read of address 120 returns 0 with `rd_valid=1`.
